// File: rtl/huffman_encoder_if.sv
// Symbol-in / serial-code-out bundle for huffman_encoder.
// master drives symbols, slave is the encoder.
interface huffman_encoder_if;
  logic [2:0] sym;
  logic       sym_valid;
  logic       sym_ready;
  logic       x;
  logic       x_valid;
  logic       last;
  logic       err;
  logic       busy;

  modport master (
    output sym, sym_valid,
    input  sym_ready, x, x_valid, last, err, busy
  );

  modport slave (
    input  sym, sym_valid,
    output sym_ready, x, x_valid, last, err, busy
  );
endinterface

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: symbol FIFO feeding a shift-out
// serializer that emits prefix-free codewords MSB first.
module huffman_encoder #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  huffman_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [2:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;

  logic        full, empty;
  logic        sym_ok, accept, push;
  logic        load, do_shift;
  logic [2:0]  head;
  logic [2:0]  len;
  logic [3:0]  code;

  logic [0:0]  state_q, state_d;
  logic [3:0]  sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        x_q, x_d;
  logic        xv_q, xv_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign sym_ok = (bus.sym != 3'b000) &&
                  (bus.sym != 3'b111);
  assign accept = bus.sym_valid && !full;
  assign push   = accept && sym_ok;
  assign err_d  = accept && !sym_ok;

  assign head = mem_q[rptr_q[AW-1:0]];

  // Codeword left-aligned in 4 bits, MSB is sent first
  always_comb begin
    len  = 3'd0;
    code = 4'b0000;
    case (head)
      3'b001: begin len = 3'd1; code = 4'b0000; end
      3'b010: begin len = 3'd3; code = 4'b1010; end
      3'b011: begin len = 3'd3; code = 4'b1000; end
      3'b100: begin len = 3'd3; code = 4'b1110; end
      3'b101: begin len = 3'd4; code = 4'b1101; end
      3'b110: begin len = 3'd4; code = 4'b1100; end
      default: ;
    endcase
  end

  // A new codeword may start on the cycle after any final bit
  assign load     = ((state_q == IDLE) || last_q) && !empty;
  assign do_shift = !load && (state_q == SHIFT) &&
                    (cnt_q != 3'd0);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    last_d  = 1'b0;
    unique case (1'b1)
      load: begin
        x_d     = code[3];
        xv_d    = 1'b1;
        last_d  = (len == 3'd1);
        sh_d    = {code[2:0], 1'b0};
        cnt_d   = len - 3'd1;
        state_d = (len > 3'd1) ? SHIFT : IDLE;
      end
      do_shift: begin
        x_d    = sh_q[3];
        xv_d   = 1'b1;
        last_d = (cnt_q == 3'd1);
        sh_d   = {sh_q[2:0], 1'b0};
        cnt_d  = cnt_q - 3'd1;
      end
      default: begin
        state_d = IDLE;
        sh_d    = 4'b0000;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d = load ? rptr_q + (AW+1)'(1) : rptr_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= bus.sym;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= IDLE;
      sh_q    <= 4'b0000;
      cnt_q   <= 3'd0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.sym_ready = !full;
  assign bus.x         = x_q;
  assign bus.x_valid   = xv_q;
  assign bus.last      = last_q;
  assign bus.err       = err_q;
  assign bus.busy      = !empty || (state_q == SHIFT);
endmodule

// File: tb/tb_huffman_encoder.sv
// Bench for huffman_encoder: trace tables, hand sequences and a
// random stream checked against a codeword-queue scoreboard.
module tb_huffman_encoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huffman_encoder_if bus();

  huffman_encoder #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  bit exp_q[$];
  bit expl_q[$];
  bit err_exp = 1'b0;

  string tx, tl, te, tr;

  typedef struct {
    logic [2:0] sym;
    string      xs;
    string      ls;
    string      es;
  } vec_t;

  vec_t tv[8];

  function automatic string code_of(logic [2:0] s);
    case (s)
      3'd1: return "0";
      3'd2: return "101";
      3'd3: return "100";
      3'd4: return "111";
      3'd5: return "1101";
      3'd6: return "1100";
      default: return "";
    endcase
  endfunction

  function automatic string decode(string bits);
    string out;
    string pre;
    out = "";
    pre = "";
    for (int i = 0; i < bits.len(); i++) begin
      if (bits[i] != "-") begin
        pre = {pre, bits.substr(i, i)};
        for (int s = 1; s < 7; s++) begin
          if (pre == code_of(3'(s))) begin
            out = {out, $sformatf("%0d", s)};
            pre = "";
          end
        end
      end
    end
    return out;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chks(string nm, string act, string req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got \"%s\" want \"%s\"", nm, act, req);
    end
  endtask

  // Scoreboard: each accepted symbol appends its codeword bits
  always @(posedge clk) begin : sb
    string c;
    err_exp = 1'b0;
    if (reset && bus.sym_valid && bus.sym_ready) begin
      c = code_of(bus.sym);
      if (c.len() == 0) err_exp = 1'b1;
      for (int i = 0; i < c.len(); i++) begin
        exp_q.push_back(c[i] == "1");
        expl_q.push_back(i == c.len() - 1);
      end
    end
  end

  always @(negedge reset) begin
    exp_q.delete();
    expl_q.delete();
    err_exp = 1'b0;
  end

  always @(negedge clk) begin : mon
    bit b;
    bit l;
    chk("err", bus.err, err_exp);
    if (bus.x_valid) begin
      chk("bit_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        l = expl_q.pop_front();
        chk("x", bus.x, b);
        chk("last", bus.last, l);
      end
    end else begin
      chk("last_idle", bus.last, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    tx = ""; tl = ""; te = ""; tr = "";
  endtask

  task automatic tick();
    step();
    if (!bus.x_valid) tx = {tx, "-"};
    else if (bus.x)   tx = {tx, "1"};
    else              tx = {tx, "0"};
    if (bus.last) tl = {tl, "L"}; else tl = {tl, "."};
    if (bus.err)  te = {te, "E"}; else te = {te, "."};
    if (bus.sym_ready) tr = {tr, "1"}; else tr = {tr, "0"};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.x_valid) && n < 100) begin
      step();
      n++;
    end
    chk("drain", {bus.busy, bus.x_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{3'd1, "-0------", ".L......", "........"};
    tv[1] = '{3'd2, "-101----", "...L....", "........"};
    tv[2] = '{3'd3, "-100----", "...L....", "........"};
    tv[3] = '{3'd4, "-111----", "...L....", "........"};
    tv[4] = '{3'd5, "-1101---", "....L...", "........"};
    tv[5] = '{3'd6, "-1100---", "....L...", "........"};
    tv[6] = '{3'd0, "--------", "........", "E......."};
    tv[7] = '{3'd7, "--------", "........", "E......."};

    reset = 1'b0;
    bus.sym = 3'd5;
    bus.sym_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_xv", bus.x_valid, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", bus.sym_ready, 1);
    end
    reset = 1'b1;
    clr();
    tick();
    bus.sym_valid = 1'b0;
    tick();
    chks("rst_latency", tx, "-1");
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      bus.sym = tv[i].sym;
      bus.sym_valid = 1'b1;
      clr();
      tick();
      bus.sym_valid = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      chks($sformatf("single_x_%0d", tv[i].sym), tx, tv[i].xs);
      chks($sformatf("single_last_%0d", tv[i].sym), tl, tv[i].ls);
      chks($sformatf("single_err_%0d", tv[i].sym), te, tv[i].es);
      wait_idle();
    end

    clr();
    bus.sym_valid = 1'b1;
    bus.sym = 3'd5; tick();
    bus.sym = 3'd1; tick();
    bus.sym = 3'd6; tick();
    bus.sym = 3'd3; tick();
    bus.sym_valid = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chks("stream_x", tx, "-110101100100---");
    chks("stream_last", tl, "....LL...L..L...");
    chks("loopback", decode(tx), "5163");
    wait_idle();

    clr();
    bus.sym = 3'd5;
    bus.sym_valid = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    bus.sym_valid = 1'b0;
    chks("full_ready", tr, "11110100010001000100");
    chks("full_x", tx, "-1101110111011101110");
    wait_idle();

    clr();
    bus.sym_valid = 1'b1;
    bus.sym = 3'd0; tick();
    bus.sym = 3'd7; tick();
    bus.sym = 3'd2; tick();
    bus.sym_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chks("inv_err", te, "EE......");
    chks("inv_x", tx, "---101--");
    wait_idle();

    clr();
    bus.sym_valid = 1'b1;
    bus.sym = 3'd5; tick();
    bus.sym = 3'd6; tick();
    bus.sym = 3'd3; tick();
    bus.sym = 3'd2; tick();
    bus.sym = 3'd4; tick();
    bus.sym_valid = 1'b0;
    tick();
    tick();
    chks("mid_pre_x", tx, "-110111");
    #2;
    reset = 1'b0;
    #1;
    chk("mid_x", bus.x, 0);
    chk("mid_xv", bus.x_valid, 0);
    chk("mid_last", bus.last, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_ready", bus.sym_ready, 1);
    step();
    reset = 1'b1;
    clr();
    for (int k = 0; k < 4; k++) tick();
    chk("post_busy", bus.busy, 0);
    bus.sym = 3'd1;
    bus.sym_valid = 1'b1;
    tick();
    bus.sym_valid = 1'b0;
    tick();
    chks("post_x", tx, "-----0");
    wait_idle();

    for (int k = 0; k < 400; k++) begin
      bus.sym = 3'($urandom_range(0, 7));
      bus.sym_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.sym_valid = 1'b0;
    wait_idle();
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/huffman_encoder.md
# huffman_encoder

Serial Huffman encoder for the 3-bit symbol alphabet used by the team's serial Huffman decoder. It accepts symbols over a valid/ready handshake into a small FIFO and emits the matching prefix-free codeword MSB-first, one bit per clock, on `x`. Consecutive codewords are emitted back-to-back with no idle bits, so a continuous stream can drive the decoder's `x` input directly.

## Interface
- `DEPTH`, default 4: symbol FIFO depth in entries. Must be a power of two and ≥ 2.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low. Low clears all state immediately.
- `sym`, input, 3: symbol to encode.
- `sym_valid`, input, 1: `sym` is valid this cycle.
- `sym_ready`, output, 1: encoder can accept a symbol; equals `!fifo_full` (combinational from registered state).
- `x`, output, 1: serial code bit, registered.
- `x_valid`, output, 1: `x` carries a code bit this cycle, registered.
- `last`, output, 1: current `x` is the final bit of a codeword, registered; only ever high together with `x_valid`.
- `err`, output, 1: one-cycle pulse, registered, for an accepted invalid symbol.
- `busy`, output, 1: FIFO non-empty or serializer has bits pending.

## Operation
- Code table (symbol → codeword, MSB first, length):
  - 001 → 0 (1)
  - 010 → 101 (3)
  - 011 → 100 (3)
  - 100 → 111 (3)
  - 101 → 1101 (4)
  - 110 → 1100 (4)
- Symbols 000 and 111 are invalid. They are accepted by the handshake, never written to the FIFO, and raise `err` on the following cycle.
- Accept rule:
  - A transfer occurs on a rising edge where `sym_valid && sym_ready`.
  - A valid symbol is pushed into the FIFO.
  - `sym_ready` is low whenever the FIFO is full, even if a pop happens in the same cycle; no push-on-full-with-pop.
- FIFO: read/write pointers are `log2(DEPTH)+1` bits wide. Full means the pointer MSBs differ and the lower bits are equal; empty means the pointers are equal. Pointers wrap modulo `2*DEPTH`.
- Serializer states:
  - IDLE: no bits pending.
  - SHIFT: a 4-bit shift register plus a 3-bit remaining-count.
- Serializer rule on each edge:
  - **Load.** Applies if (IDLE, or SHIFT with the current output being `last`) and the FIFO is non-empty. Pop one entry. Set `x` to codeword bit MSB, `x_valid` to 1, and `last` to (len==1). Load the remaining len−1 bits and set the state to SHIFT if len>1. A length-1 code goes to IDLE with `last` already high.
  - **Shift.** Applies otherwise, if bits remain. Output the next bit, decrement the count, and set `last` when count reaches 1→0.
  - **Otherwise.** Set `x`=0, `x_valid`=0, `last`=0, state IDLE.
- Push and pop in the same cycle are both honoured; FIFO occupancy is unchanged.
- `busy` = `!fifo_empty || (state==SHIFT)`.
- Idle `x` is 0. A decoder driven without gating on `x_valid` will decode idle as symbol 001; consumers must gate on `x_valid`.

## Timing
- Values while `reset` is low: `x`=0, `x_valid`=0, `last`=0, `err`=0, `busy`=0, FIFO empty, `sym_ready`=1.
- Latency with FIFO and serializer empty: a symbol accepted at edge E0 produces its first bit on `x` after edge E1, so it is visible one cycle after acceptance.
- A codeword of length L occupies exactly L consecutive `x_valid` cycles.
- With the FIFO non-empty, the next codeword's first bit follows the previous `last` bit on the very next cycle, with zero gap.
- `err` is high for exactly the cycle after the edge that accepted the invalid symbol. Back-to-back invalid symbols give consecutive `err` cycles.
- Reset asserted mid-codeword: output is truncated immediately, the FIFO contents are discarded, and the first transfer after release starts a fresh codeword.
- Throughput: sustained input faster than one symbol per average code length fills the FIFO; `sym_ready` then throttles.

## Test plan
- **Reset.** Hold `reset` low 3 cycles with `sym_valid`=1. Required: `x_valid`=0, `err`=0, `busy`=0, `sym_ready`=1 throughout. After release, the first accepted symbol gets latency 1.
- **Single symbols.** Send each of 001…110 alone, with idle in between. Required: the `x` sequences are 0, 101, 100, 111, 1101, 1100; `x_valid` lasts 1, 3, 3, 3, 4, 4 cycles; `last` is high only on the final bit.
- **Back-to-back and loopback.** Stream 101,001,110,011 continuously. Required: `x` = 1101 0 1100 100 with no `x_valid` gap across all 12 bits. The serial decoder fed this `x` (starting from its reset) shows y=101,001,110,011, each in the cycle after the corresponding `last` bit.
- **Full FIFO.** Hold `sym_valid`=1 with symbol 101 for 20 cycles. Required: `sym_ready` drops after DEPTH entries plus one in the serializer. It re-asserts for one cycle per pop (every 4 cycles), and the output is a gapless sequence of repeated 1101 codewords.
- **Invalid symbols.** Send 000, 111, then 010. Required: `err` is high for 2 consecutive cycles, neither invalid symbol produces an `x_valid` bit, and the output is 101.
- **Reset mid-operation.** Pull `reset` low on the second bit of 1100 with 3 entries queued. Required: outputs go to 0 asynchronously; after release `busy`=0 and no stale bits appear.
